// File: rtl/pipe_cla_sub.sv
// pipe_cla_sub: pipelined a - b - bin, one 4-bit carry-lookahead nibble resolved per stage,
// with valid/ready handshaking and per-stage skid-free load enables.
module pipe_cla_sub #(
  parameter int NNIB = 4,
  localparam int W = 4*NNIB
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         bin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] diff,
  output logic         bout,
  output logic         ovf
);
  logic [NNIB-1:0] vr, ld, cr, xr;
  logic [W-1:0] dr [NNIB];
  logic [W-1:0] br [NNIB-1];
  genvar k;
  for (k = 0; k < NNIB; k++) begin : g_st
    logic [W-1:0] ai;
    logic [3:0] an, bn, g, p, s;
    logic [4:0] c;
    logic vi, ci, xi;
    if (k == 0) begin : g_in
      assign ai = a;
      assign bn = ~b[3:0];
      assign vi = in_valid;
      assign ci = ~bin;
      assign xi = a[W-1] ^ b[W-1];
    end else begin : g_chain
      assign ai = dr[k-1];
      assign bn = ~br[k-1][4*k+:4];
      assign vi = vr[k-1];
      assign ci = cr[k-1];
      assign xi = xr[k-1];
    end
    if (k == NNIB-1) begin : g_ld_last
      assign ld[k] = ~vr[k] | out_ready;
    end else begin : g_ld_mid
      assign ld[k] = ~vr[k] | ld[k+1];
    end
    assign an = ai[4*k+:4];
    assign g = an & bn;
    assign p = an ^ bn;
    assign c = {g[3] | (p[3] & g[2]) | (&p[3:2] & g[1]) | (&p[3:1] & g[0]) | (&p[3:0] & ci),
                g[2] | (p[2] & g[1]) | (&p[2:1] & g[0]) | (&p[2:0] & ci),
                g[1] | (p[1] & g[0]) | (&p[1:0] & ci),
                g[0] | (p[0] & ci),
                ci};
    assign s = p ^ c[3:0];
    // the last stage still sees a's msb, so it resolves ovf in place of the msb-xor bit
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        vr[k] <= 1'b0;
        dr[k] <= '0;
        cr[k] <= 1'b0;
        xr[k] <= 1'b0;
      end else if (ld[k]) begin
        vr[k] <= vi;
        dr[k] <= ai;
        dr[k][4*k+:4] <= s;
        cr[k] <= c[4];
        xr[k] <= (k == NNIB-1) ? xi & (ai[W-1] ^ s[3]) : xi;
      end
    if (k < NNIB-1) begin : g_b
      logic [W-1:0] bw;
      if (k == 0) begin : g_b0
        assign bw = b;
      end else begin : g_bn
        assign bw = br[k-1];
      end
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) br[k] <= '0;
        else if (ld[k]) br[k] <= bw;
    end
  end
  assign in_ready = ld[0];
  assign out_valid = vr[NNIB-1];
  assign diff = dr[NNIB-1];
  assign bout = vr[NNIB-1] & ~cr[NNIB-1];
  assign ovf = xr[NNIB-1];
endmodule

// File: tb/tb_pipe_cla_sub.sv
// tb_pipe_cla_sub: directed and randomized checks of the pipelined subtractor.
module tb_pipe_cla_sub;
  logic clk, rst_n, in_valid, in_ready, bin, out_valid, out_ready, bout, ovf;
  logic [15:0] a, b, diff;
  int nchk = 0, nerr = 0;
  logic [17:0] q [$];

  pipe_cla_sub #(.NNIB(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .bout(bout), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y, input logic bi);
    int sd, ud;
    sd = int'($signed(x)) - int'($signed(y)) - int'(bi);
    ud = int'(x) - int'(y) - int'(bi);
    return {(sd > 32767 || sd < -32768), ud < 0, ud[15:0]};
  endfunction

  task automatic send1(input string tag, input logic [15:0] x, input logic [15:0] y,
                       input logic bi, input logic [17:0] exp);
    int n = 0;
    a = x; b = y; bin = bi; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk({tag, "_rdy"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_lat"}, n, 3);
    chk(tag, {ovf, bout, diff}, exp);
  endtask

  task automatic stream(input string tag, input int nsets, input int stall, input bit rnd);
    int sent = 0, got = 0, cyc = 0;
    bit held = 0, drop = 0;
    logic [17:0] hv, e;
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    q.delete();
    while (got < nsets && cyc < nsets * 8 + 100) begin
      out_ready = rnd ? ($urandom_range(0, 3) != 0) : (cyc >= stall);
      in_valid = (sent < nsets) && (!rnd || $urandom_range(0, 3) != 0);
      a = 16'($urandom); b = 16'($urandom); bin = 1'($urandom);
      #1;
      if (held) chk({tag, "_hold"}, {ovf, bout, diff}, hv);
      if (!rnd && !drop && !in_ready) begin
        drop = 1;
        chk({tag, "_drop_after"}, sent, 4);
      end
      if (!rnd && out_ready) chk({tag, "_rdy_pass"}, in_ready, 1);
      if (out_valid && out_ready) begin
        chk({tag, "_unexpected"}, q.size() > 0, 1);
        e = (q.size() > 0) ? q.pop_front() : 18'h0;
        chk({tag, "_res"}, {ovf, bout, diff}, e);
        got++;
      end
      held = out_valid && !out_ready;
      hv = {ovf, bout, diff};
      if (in_valid && in_ready) begin
        q.push_back(model(a, b, bin));
        sent++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk({tag, "_count"}, got, nsets);
    chk({tag, "_left"}, q.size(), 0);
    if (!rnd) chk({tag, "_drop_seen"}, drop, 1);
  endtask

  initial begin
    int stale = 0;
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; bin = 1'b0; out_ready = 1'b1;
    #3;
    chk("rst_ovalid", out_valid, 0);
    chk("rst_diff", diff, 0);
    chk("rst_bout", bout, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_irdy", in_ready, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send1("basic", 16'h1234, 16'h0234, 1'b0, 18'h01000);
    send1("wrap", 16'h0000, 16'h0001, 1'b0, 18'h1FFFF);
    send1("ripple", 16'h1000, 16'h0001, 1'b0, 18'h00FFF);
    send1("ovf_neg", 16'h8000, 16'h0001, 1'b0, 18'h27FFF);
    send1("bin_only", 16'h0000, 16'h0000, 1'b1, 18'h1FFFF);
    send1("ovf_pos", 16'h7FFF, 16'hFFFF, 1'b0, 18'h38000);
    send1("all_ones", 16'hFFFF, 16'hFFFF, 1'b1, 18'h1FFFF);
    stream("stall", 8, 6, 1'b0);
    stream("rand", 10000, 0, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; a = 16'(16'h0100 * (i + 1)); b = 16'h0001; bin = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("rst_pre_ovalid", out_valid, 1);
    out_ready = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_ovalid", out_valid, 0);
    chk("rst_mid_out", {ovf, bout, diff}, 0);
    chk("rst_mid_irdy", in_ready, 1);
    @(posedge clk); #1;
    rst_n = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      stale += int'(out_valid);
      @(posedge clk); #1;
    end
    chk("rst_stale", stale, 0);
    send1("post_rst", 16'h5555, 16'h1111, 1'b1, 18'h04443);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule

// File: doc/pipe_cla_sub.md
PIPE_CLA_SUB -- requirements
Module: pipe_cla_sub

Interface
REQ-001 The parameter NNIB SHALL default to 4; it is the number of 4-bit nibble stages, giving operand width W = 4*NNIB (16 by default).
REQ-002 Port clk SHALL be an input, 1 bit wide; it is the single clock, and all state SHALL update on its rising edge.
REQ-003 Port rst_n SHALL be an input, 1 bit wide; it is the asynchronous, active-low reset.
REQ-004 Port in_valid SHALL be an input, 1 bit wide; when high, the upstream source is presenting an operand set.
REQ-005 Port in_ready SHALL be an output, 1 bit wide; when high, the block can accept an operand set this cycle.
REQ-006 Port a SHALL be an input, W bits wide; it is the minuend.
REQ-007 Port b SHALL be an input, W bits wide; it is the subtrahend.
REQ-008 Port bin SHALL be an input, 1 bit wide; it is the borrow-in.
REQ-009 Port out_valid SHALL be an output, 1 bit wide; when high, a result is being presented.
REQ-010 Port out_ready SHALL be an input, 1 bit wide; when high, the downstream sink accepts the result.
REQ-011 Port diff SHALL be an output, W bits wide; it is the difference, a - b - bin mod 2^W.
REQ-012 Port bout SHALL be an output, 1 bit wide; it is the borrow-out, high iff a < b + bin as unsigned values.
REQ-013 Port ovf SHALL be an output, 1 bit wide; it flags two's-complement signed overflow.

Function
REQ-014 The datapath SHALL compute a + ~b + ~bin using 4-bit carry-lookahead slices, with borrow = ~carry; nibble k SHALL be resolved in pipeline stage k.
REQ-015 Each stage k SHALL register: a valid bit, the resolved diff nibbles 0..k, the unresolved a/b nibbles k+1..NNIB-1, the carry out of nibble k, and a[W-1]^b[W-1].
REQ-016 A transfer SHALL occur on a rising edge when in_valid&in_ready (input side) or out_valid&out_ready (output side).
REQ-017 Stage k SHALL be able to load when its valid bit is 0 or stage k+1 can load; the last stage SHALL be able to load when its valid bit is 0 or out_ready=1.
REQ-018 in_ready SHALL equal the can-load term of stage 0; it is combinational from out_ready and state only, never from in_valid.
REQ-019 Latency: a set accepted at edge E SHALL have out_valid=1 after edge E+NNIB-1 when no stall occurs.
REQ-020 Throughput SHALL be one result per cycle when out_ready is held at 1.
REQ-021 Results SHALL leave in acceptance order; none SHALL be dropped or duplicated.
REQ-022 While out_valid=1 and out_ready=0, diff, bout and ovf SHALL be held stable.
REQ-023 When all NNIB stages are valid and out_ready=0, in_ready SHALL be 0; when out_ready=1, in_ready SHALL be 1.
REQ-024 Input and output transfers in the same cycle SHALL both complete with no bubble inserted.
REQ-025 bout SHALL be the inverted carry out of nibble NNIB-1.
REQ-026 ovf SHALL equal (a[W-1]^b[W-1]) & (a[W-1]^diff[W-1]).
REQ-027 When out_valid=0, the values of diff, bout and ovf SHALL be don't-care, but SHALL be X-free.

Reset
REQ-028 When rst_n=0, all stage valid bits SHALL clear immediately and asynchronously, and out_valid SHALL be 0.
REQ-029 When rst_n=0, diff, bout and ovf SHALL be 0, and in_ready SHALL be 1 while out_ready is 1.
REQ-030 Assertion of rst_n mid-stream SHALL discard all in-flight sets; the first set accepted after release SHALL be handled normally.

Verification
REQ-031 The bench SHALL drive a=0x1234, b=0x0234, bin=0, and SHALL check diff=0x1000, bout=0, ovf=0, with out_valid rising exactly 3 edges after the acceptance edge.
REQ-032 The bench SHALL drive a=0x0000, b=0x0001, bin=0, and SHALL check diff=0xFFFF, bout=1, ovf=0; it SHALL then drive a=0x1000, b=0x0001, and check diff=0x0FFF with the borrow rippling across all nibbles.
REQ-033 The bench SHALL drive a=0x8000, b=0x0001, bin=0, and SHALL check diff=0x7FFF, bout=0, ovf=1; it SHALL then drive a=0x0000, b=0x0000, bin=1, and check diff=0xFFFF, bout=1.
REQ-034 The bench SHALL stream 8 back-to-back sets while holding out_ready=0 for 6 cycles, and SHALL check that in_ready drops after 4 acceptances, outputs stay stable while stalled, and all 8 results return in order.
REQ-035 The bench SHALL drive random in_valid/out_ready over 10k sets and SHALL check every result against a reference model computing (a-b-bin) mod 2^16, the borrow and ovf.
REQ-036 The bench SHALL pulse rst_n low with 3 sets in flight, and SHALL check that out_valid drops with no clock edge, no stale result appears afterwards, and a new set accepted after release completes correctly.
